// File: rtl/quad_encoder_rx_if.sv
// Bundle of signals between the quadrature encoder receiver and its controller.
// Encoder lines and the position clear go into the receiver; decoded results come back.
interface quad_encoder_rx_if #(
    parameter int POS_W = 16,
    parameter int SPD_W = 16
);
    logic             enc_a;
    logic             enc_b;
    logic             clr_pos;
    logic [POS_W-1:0] position;
    logic             dir_fb;
    logic [SPD_W-1:0] speed;
    // speed_valid is a single-cycle pulse with no ready: the consumer must take speed then.
    logic             speed_valid;
    logic             step_err;

    modport master (
        output enc_a, enc_b, clr_pos,
        input  position, dir_fb, speed, speed_valid, step_err
    );

    modport slave (
        input  enc_a, enc_b, clr_pos,
        output position, dir_fb, speed, speed_valid, step_err
    );
endinterface

// File: rtl/quad_encoder_rx.sv
// x4 quadrature decoder: synchronized A/B to signed position, direction, windowed speed.
// Define QUAD_ENC_GLITCH_FILTER_EN to insert a FILT_CYCLES stability filter after the synchronizers.
module quad_encoder_rx #(
    parameter int WINDOW_CYCLES = 500000,
    parameter int POS_W         = 16,
    parameter int SPD_W         = 16,
    parameter int FILT_CYCLES   = 4
) (
    input logic              clk,
    input logic              rst,
    quad_encoder_rx_if.slave bus
);
    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);

    if (WINDOW_CYCLES < 1 || FILT_CYCLES < 1) begin : g_param_chk
        $error("quad_encoder_rx: WINDOW_CYCLES and FILT_CYCLES must be at least 1");
    end

    logic r_a_s1, r_a_s2, r_b_s1, r_b_s2;
    logic w_a, w_b;

    // Encoder lines are asynchronous; the synchronizer needs no reset.
    always_ff @(posedge clk) begin
        r_a_s1 <= bus.enc_a;
        r_a_s2 <= r_a_s1;
        r_b_s1 <= bus.enc_b;
        r_b_s2 <= r_b_s1;
    end

`ifdef QUAD_ENC_GLITCH_FILTER_EN
    localparam int FC_W = $clog2(FILT_CYCLES + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYCLES - 1);

    logic [FC_W-1:0] r_a_cnt, r_b_cnt;
    logic            r_a_filt, r_b_filt;

    // The counter measures how long s2 has disagreed with the filtered value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a_cnt  <= '0;
            r_b_cnt  <= '0;
            r_a_filt <= r_a_s2;
            r_b_filt <= r_b_s2;
        end else begin
            if (r_a_s2 == r_a_filt) begin
                r_a_cnt <= '0;
            end else if (r_a_cnt == FC_LAST) begin
                r_a_cnt  <= '0;
                r_a_filt <= r_a_s2;
            end else begin
                r_a_cnt <= r_a_cnt + FC_W'(1);
            end
            if (r_b_s2 == r_b_filt) begin
                r_b_cnt <= '0;
            end else if (r_b_cnt == FC_LAST) begin
                r_b_cnt  <= '0;
                r_b_filt <= r_b_s2;
            end else begin
                r_b_cnt <= r_b_cnt + FC_W'(1);
            end
        end
    end

    assign w_a = r_a_filt;
    assign w_b = r_b_filt;
`else
    assign w_a = r_a_s2;
    assign w_b = r_b_s2;
`endif

    logic [1:0] r_ab_q;
    logic [1:0] w_cur;
    logic       w_fwd, w_rev, w_err, w_step;

    assign w_cur  = {w_a, w_b};
    assign w_step = w_fwd | w_rev;

    // Loading every cycle, reset included, means reset release never looks like a step.
    always_ff @(posedge clk) begin
        r_ab_q <= w_cur;
    end

    always_comb begin
        w_fwd = 1'b0;
        w_rev = 1'b0;
        w_err = 1'b0;
        case ({r_ab_q, w_cur})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_fwd = 1'b1;
            4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: w_rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: w_err = 1'b1;
            default: ;
        endcase
    end

    logic [POS_W-1:0] r_position;
    logic             r_dir_fb;
    logic             r_step_err;

    // clr_pos wins over a step or an error decoded in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_position <= '0;
            r_dir_fb   <= 1'b0;
            r_step_err <= 1'b0;
        end else begin
            if (w_fwd) begin
                r_dir_fb <= 1'b0;
            end else if (w_rev) begin
                r_dir_fb <= 1'b1;
            end
            if (bus.clr_pos) begin
                r_position <= '0;
                r_step_err <= 1'b0;
            end else begin
                if (w_fwd) begin
                    r_position <= r_position + POS_W'(1);
                end else if (w_rev) begin
                    r_position <= r_position - POS_W'(1);
                end
                if (w_err) begin
                    r_step_err <= 1'b1;
                end
            end
        end
    end

    logic [WIN_W-1:0] r_win_cnt;
    logic [SPD_W-1:0] r_acc;
    logic [SPD_W-1:0] r_speed;
    logic             r_speed_valid;
    logic [SPD_W-1:0] w_acc_next;
    logic             w_win_last;

    assign w_win_last = (r_win_cnt == WIN_LAST);
    assign w_acc_next = (w_step && (r_acc != '1)) ? r_acc + SPD_W'(1) : r_acc;

    // The closing cycle's own step is folded into the published speed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_win_cnt     <= '0;
            r_acc         <= '0;
            r_speed       <= '0;
            r_speed_valid <= 1'b0;
        end else begin
            r_speed_valid <= w_win_last;
            if (w_win_last) begin
                r_win_cnt <= '0;
                r_acc     <= '0;
                r_speed   <= w_acc_next;
            end else begin
                r_win_cnt <= r_win_cnt + WIN_W'(1);
                r_acc     <= w_acc_next;
            end
        end
    end

    assign bus.position    = r_position;
    assign bus.dir_fb      = r_dir_fb;
    assign bus.step_err    = r_step_err;
    assign bus.speed       = r_speed;
    assign bus.speed_valid = r_speed_valid;
endmodule

// File: doc/quad_encoder_rx.md
# quad_encoder_rx

Quadrature encoder receiver for the motor drive path. Samples the A/B channels of the motor shaft encoder, then decodes them in x4 mode into a signed position count and a direction flag. It also measures speed as the number of edges per fixed window. It is the feedback end of the PWM/L298 drive channel, and it lets the controller close the loop on the duty cycle it commands.

## Interface
- `WINDOW_CYCLES`, 500000: clock cycles per speed-measurement window (10 ms at 50 MHz).
- `POS_W`, 16: width of the signed position counter.
- `SPD_W`, 16: width of the unsigned speed count.
- `FILT_CYCLES`, 4: stability length of the glitch filter; used only when the filter is compiled in.
- `clk` in 1: 50 MHz system clock. Every flop is clocked on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `enc_a` in 1: encoder channel A, asynchronous to `clk`.
- `enc_b` in 1: encoder channel B, asynchronous to `clk`.
- `clr_pos` in 1: synchronous clear of `position` and `step_err`.
- `position` out POS_W: signed two's-complement x4 edge count.
- `dir_fb` out 1: direction of the last valid step. 0 = forward (A leads B), 1 = reverse.
- `speed` out SPD_W: valid steps counted in the last completed window, unsigned.
- `speed_valid` out 1: one-cycle pulse when `speed` updates.
- `step_err` out 1: sticky flag for an illegal transition.

## Operation
- **Synchronizer.** Each input passes through a 2-flop synchronizer (`s1`, `s2`). These flops are not reset.
- **State register.** `ab_q` holds the previous sampled `{A,B}`.
  - While `rst` = 0, `ab_q` loads the current `{A_s2,B_s2}`. Reset release therefore never produces a step or an error.
- **Decode.** Compare `cur = {A_s2,B_s2}` against `ab_q` every cycle.
  - Forward, +1: 00→10, 10→11, 11→01, 01→00.
  - Reverse, −1: the inverse transitions.
  - `cur == ab_q`: no action.
  - Both bits changed: `step_err` ← 1. `position` and `dir_fb` are unchanged.
  - `ab_q` ← `cur` every cycle.
- **Position.** Adds +1 or −1 modulo 2^POS_W.
  - Wraps from 0x7FFF to 0x8000 and from 0x8000 to 0x7FFF. There is no saturation.
- **Direction.** `dir_fb` updates only on a valid step.
- **Clear.** `clr_pos` = 1 sets `position` ← 0 and `step_err` ← 0.
  - It overrides a same-cycle step or error.
- **Speed window.** `win_cnt` counts 0..WINDOW_CYCLES−1 and then wraps.
  - `acc` counts valid steps in both directions and saturates at 2^SPD_W−1.
  - On the cycle where `win_cnt` = WINDOW_CYCLES−1:
    - `speed` ← `acc` plus that cycle's step (saturating).
    - `speed_valid` ← 1 for exactly one cycle.
    - `acc` ← 0.
  - An illegal transition does not increment `acc`.
- **Reset.** While `rst` = 0:
  - `position` = 0, `speed` = 0, `speed_valid` = 0, `dir_fb` = 0, `step_err` = 0.
  - `win_cnt` = 0, `acc` = 0.
  - A reset mid-window discards the partial count. The first `speed_valid` comes WINDOW_CYCLES cycles after release.

## Timing
- **Decode latency.** An input change that meets setup before rising edge k is captured in `s1` at k and in `s2` at k+1. `position`, `dir_fb` and `step_err` update at edge k+2. Total: 3 edges, filter absent.
- **Filter latency.** Add FILT_CYCLES edges when the filter is compiled in.
- **Step rate.** At most one step per clock. Maximum input edge rate is one transition per channel every 2 cycles, or every FILT_CYCLES+1 cycles with the filter. Faster input can produce `step_err`.
- **Speed cadence.** `speed_valid` period is exactly WINDOW_CYCLES cycles. `speed` holds its value between pulses.
- **Outputs.** All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `QUAD_ENC_GLITCH_FILTER_EN` defined:
  - A per-channel filter is inserted after `s2`.
  - The filtered bit takes the new value only after `s2` has held it for FILT_CYCLES consecutive cycles.
  - Any shorter pulse is discarded.
  - The filter counters reset to 0. The filtered value tracks `s2` while in reset.
- Undefined: `s2` feeds the decoder directly, with no filter logic synthesized.

## Test plan
- **Reset release.** Hold A=B=1 through reset, then release → no step, `step_err` = 0, `position` = 0.
- **Forward and reverse.** Apply 8 forward transitions (00→10→11→01→00, twice), 4 cycles apart → `position` = 8, `dir_fb` = 0. Then apply 3 reverse transitions → `position` = 5, `dir_fb` = 1. Each update occurs 3 edges after its input change.
- **Wrap and clear.** Preload to 0x7FFF via 32767 forward steps, then one more step → 0x8000. Assert `clr_pos` in the same cycle as a step → `position` = 0.
- **Illegal transition.** Drive 00→11 → `step_err` = 1 and `position` unchanged. `step_err` persists until `clr_pos`.
- **Speed.** With WINDOW_CYCLES = 100, apply a step every 10 cycles → `speed_valid` every 100 cycles with `speed` = 10 (±0 once aligned). A reset mid-window → next pulse 100 cycles after release.
- **Glitch filter.** With `QUAD_ENC_GLITCH_FILTER_EN` and FILT_CYCLES = 4:
  - A 3-cycle pulse on A → no step.
  - A 4-cycle hold → one step.
